// File: rtl/reg_file_pkg.sv
// Shared constants and types for the architectural register file.
// The ROB_WIDTH_BIT/REG_NUM/REG_ZERO macros come from the core-wide constants; defaults apply only if absent.
`ifndef ROB_WIDTH_BIT
`define ROB_WIDTH_BIT 4
`endif
`ifndef REG_NUM
`define REG_NUM 32
`endif
`ifndef REG_ZERO
`define REG_ZERO 0
`endif

package reg_file_pkg;
  localparam int REG_NUM  = `REG_NUM;
  localparam int REG_ZERO = `REG_ZERO;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 6;

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/reg_read_port.sv
// One combinational source-operand lookup: index select, x0 override and,
// with REG_BYPASS_EN defined, same-cycle forwarding of a matching commit.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_WIDTH   = `ROB_WIDTH_BIT,
  parameter int REG_NUM_BIT = 5
) (
  input  logic [REG_NUM_BIT-1:0] idx,
  input  word_t                  val_tbl [REG_NUM],
  input  logic [REG_NUM-1:0]     busy_vec,
  input  logic [ROB_WIDTH-1:0]   tag_tbl [REG_NUM],
`ifdef REG_BYPASS_EN
  input  logic                   byp_en,
  input  logic [ROB_WIDTH-1:0]   byp_tag,
  input  word_t                  byp_val,
`endif
  output word_t                  val,
  output logic                   busy,
  output logic [ROB_WIDTH-1:0]   tag
);

  localparam logic [REG_NUM_BIT-1:0] ZERO_IDX = REG_NUM_BIT'(REG_ZERO);

  always_comb begin
    val  = val_tbl[idx];
    busy = busy_vec[idx];
    tag  = busy_vec[idx] ? tag_tbl[idx] : '0;
`ifdef REG_BYPASS_EN
    if (busy && byp_en && (tag == byp_tag)) begin
      val  = byp_val;
      busy = 1'b0;
      tag  = '0;
    end
`endif
    if (idx == ZERO_IDX) begin
      val  = '0;
      busy = 1'b0;
      tag  = '0;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with ROB rename tags: commit writes, tail renames, flush.
// Optional macro REG_BYPASS_EN forwards a matching commit to the read ports in the same cycle.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_WIDTH   = `ROB_WIDTH_BIT,
  parameter int REG_NUM_BIT = 5
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   clear,
  input  logic                   commit_en,
  input  logic [REG_NUM_BIT-1:0] commit_rd,
  input  word_t                  commit_val,
  input  logic [ROB_WIDTH-1:0]   commit_rob_id,
  input  logic                   rename_en,
  input  logic [REG_NUM_BIT-1:0] rename_rd,
  input  logic [ROB_WIDTH-1:0]   rename_rob_id,
  input  logic [REG_NUM_BIT-1:0] rs1_idx,
  input  logic [REG_NUM_BIT-1:0] rs2_idx,
  output word_t                  rs1_val,
  output word_t                  rs2_val,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [ROB_WIDTH-1:0]   rs1_tag,
  output logic [ROB_WIDTH-1:0]   rs2_tag,
  output logic [CNT_W-1:0]       busy_cnt
);

  localparam logic [REG_NUM_BIT-1:0] ZERO_IDX = REG_NUM_BIT'(REG_ZERO);

  word_t                val_q [REG_NUM];
  logic [REG_NUM-1:0]   busy_q;
  logic [ROB_WIDTH-1:0] tag_q [REG_NUM];

  logic cmt_wr, ren_wr, cmt_clr, cnt_inc, cnt_dec;

  // A rename to the register a commit is releasing keeps it busy, so the count holds.
  always_comb begin
    cmt_wr  = rdy_in && commit_en && (commit_rd != ZERO_IDX);
    ren_wr  = rdy_in && rename_en && (rename_rd != ZERO_IDX) && !clear;
    cmt_clr = cmt_wr && busy_q[commit_rd] && (tag_q[commit_rd] == commit_rob_id);
    cnt_inc = ren_wr && !busy_q[rename_rd];
    cnt_dec = cmt_clr && !(ren_wr && (rename_rd == commit_rd));
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q   <= '0;
      busy_cnt <= '0;
    end else if (rdy_in) begin
      if (cmt_wr) val_q[commit_rd] <= commit_val;
      if (clear) begin
        for (int i = 0; i < REG_NUM; i++) tag_q[i] <= '0;
        busy_q   <= '0;
        busy_cnt <= '0;
      end else begin
        if (cmt_clr) begin
          busy_q[commit_rd] <= 1'b0;
          tag_q[commit_rd]  <= '0;
        end
        // Later assignment lets a same-cycle rename override the commit release.
        if (ren_wr) begin
          busy_q[rename_rd] <= 1'b1;
          tag_q[rename_rd]  <= rename_rob_id;
        end
        busy_cnt <= busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
      end
    end
  end

`ifdef REG_BYPASS_EN
  logic byp_en;
  assign byp_en = rdy_in && commit_en;
`endif

  reg_read_port #(.ROB_WIDTH(ROB_WIDTH), .REG_NUM_BIT(REG_NUM_BIT)) u_rs1 (
    .idx      (rs1_idx),
    .val_tbl  (val_q),
    .busy_vec (busy_q),
    .tag_tbl  (tag_q),
`ifdef REG_BYPASS_EN
    .byp_en   (byp_en),
    .byp_tag  (commit_rob_id),
    .byp_val  (commit_val),
`endif
    .val      (rs1_val),
    .busy     (rs1_busy),
    .tag      (rs1_tag)
  );

  reg_read_port #(.ROB_WIDTH(ROB_WIDTH), .REG_NUM_BIT(REG_NUM_BIT)) u_rs2 (
    .idx      (rs2_idx),
    .val_tbl  (val_q),
    .busy_vec (busy_q),
    .tag_tbl  (tag_q),
`ifdef REG_BYPASS_EN
    .byp_en   (byp_en),
    .byp_tag  (commit_rob_id),
    .byp_val  (commit_val),
`endif
    .val      (rs2_val),
    .busy     (rs2_busy),
    .tag      (rs2_tag)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed vector table, corner sequences,
// then randomized traffic against an array-based reference model.
module tb_reg_file;
  import reg_file_pkg::*;

  localparam int RW = `ROB_WIDTH_BIT;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, clear, commit_en, rename_en;
  logic [4:0]    commit_rd, rename_rd, rs1_idx, rs2_idx;
  logic [31:0]   commit_val, rs1_val, rs2_val;
  logic [RW-1:0] commit_rob_id, rename_rob_id, rs1_tag, rs2_tag;
  logic          rs1_busy, rs2_busy;
  logic [5:0]    busy_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .commit_en(commit_en), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .rename_en(rename_en), .rename_rd(rename_rd),
    .rename_rob_id(rename_rob_id), .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag), .busy_cnt(busy_cnt)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit rdy; bit clr;
    bit ce; bit [4:0] crd; bit [31:0] cval; bit [RW-1:0] cid;
    bit re; bit [4:0] rrd; bit [RW-1:0] rid;
    bit [4:0] r1; bit [31:0] e1v; bit e1b; bit [RW-1:0] e1t;
    bit [4:0] r2; bit [31:0] e2v; bit e2b; bit [RW-1:0] e2t;
    bit [5:0] ecnt;
  } vec_t;

  vec_t tbl[$];

  // Reference model: plain per-register arrays, count derived by popcount.
  bit [31:0]   m_val  [32];
  bit          m_busy [32];
  bit [RW-1:0] m_tag  [32];

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endfunction

  function automatic void model_step(bit rdy, bit clr, bit ce, bit [4:0] crd, bit [31:0] cval,
                                     bit [RW-1:0] cid, bit re, bit [4:0] rrd, bit [RW-1:0] rid);
    if (!rdy) return;
    if (ce && crd != 0) m_val[crd] = cval;
    if (clr) begin
      for (int i = 0; i < 32; i++) begin m_busy[i] = 1'b0; m_tag[i] = '0; end
      return;
    end
    if (ce && crd != 0 && m_busy[crd] && m_tag[crd] == cid) begin
      m_busy[crd] = 1'b0; m_tag[crd] = '0;
    end
    if (re && rrd != 0) begin m_busy[rrd] = 1'b1; m_tag[rrd] = rid; end
  endfunction

  function automatic int model_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic vec_t mk(bit rdy, bit clr, bit ce, bit [4:0] crd, bit [31:0] cval, bit [RW-1:0] cid,
                              bit re, bit [4:0] rrd, bit [RW-1:0] rid,
                              bit [4:0] r1, bit [31:0] e1v, bit e1b, bit [RW-1:0] e1t,
                              bit [4:0] r2, bit [31:0] e2v, bit e2b, bit [RW-1:0] e2t, bit [5:0] ecnt);
    vec_t v;
    v.rdy = rdy; v.clr = clr; v.ce = ce; v.crd = crd; v.cval = cval; v.cid = cid;
    v.re = re; v.rrd = rrd; v.rid = rid;
    v.r1 = r1; v.e1v = e1v; v.e1b = e1b; v.e1t = e1t;
    v.r2 = r2; v.e2v = e2v; v.e2b = e2b; v.e2t = e2t; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_port(input string nm, input logic [31:0] v, input logic b, input logic [RW-1:0] t,
                          input logic [31:0] ev, input logic eb, input logic [RW-1:0] et);
    chk({nm, ".val"}, v, ev);
    chk({nm, ".busy"}, 32'(b), 32'(eb));
    chk({nm, ".tag"}, 32'(t), 32'(et));
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0; commit_en = 1'b0; rename_en = 1'b0;
    commit_rd = '0; commit_val = '0; commit_rob_id = '0; rename_rd = '0; rename_rob_id = '0;
  endtask

  task automatic drive(bit rdy, bit clr, bit ce, bit [4:0] crd, bit [31:0] cval, bit [RW-1:0] cid,
                       bit re, bit [4:0] rrd, bit [RW-1:0] rid);
    rdy_in = rdy; clear = clr; commit_en = ce; commit_rd = crd; commit_val = cval;
    commit_rob_id = cid; rename_en = re; rename_rd = rrd; rename_rob_id = rid;
  endtask

  function automatic void exp_read(bit [4:0] idx, output bit [31:0] ev, output bit eb, output bit [RW-1:0] et);
    ev = m_val[idx]; eb = m_busy[idx]; et = m_busy[idx] ? m_tag[idx] : '0;
`ifdef REG_BYPASS_EN
    if (eb && rdy_in && commit_en && et == commit_rob_id) begin
      ev = commit_val; eb = 1'b0; et = '0;
    end
`endif
    if (idx == 0) begin ev = '0; eb = 1'b0; et = '0; end
  endfunction

  initial begin
    vec_t v;
    bit [31:0] ev; bit eb; bit [RW-1:0] et;

    // ---- reset state ----
    idle(); rst_in = 1'b1; rs1_idx = 5'd3; rs2_idx = 5'd0;
    #2;
    chk_port("rst_during.x3", rs1_val, rs1_busy, rs1_tag, 32'h0, 1'b0, '0);
    chk("rst_during.cnt", 32'(busy_cnt), 32'd0);
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b0;
    #1 chk_port("rst_after.x3", rs1_val, rs1_busy, rs1_tag, 32'h0, 1'b0, '0);

    // ---- directed vector table ----
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b0,5'd0,4'd0,  5'd3,32'h0,1'b0,4'd0,     5'd0,32'h0,1'b0,4'd0,   6'd0));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd5,4'd4,  5'd5,32'h0,1'b1,4'd4,     5'd3,32'h0,1'b0,4'd0,   6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b1,5'd5,32'h1234,4'd4,  1'b0,5'd0,4'd0,  5'd5,32'h1234,1'b0,4'd0,  5'd0,32'h0,1'b0,4'd0,   6'd0));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd7,4'd2,  5'd7,32'h0,1'b1,4'd2,     5'd5,32'h1234,1'b0,4'd0, 6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd7,4'd6,  5'd7,32'h0,1'b1,4'd6,     5'd0,32'h0,1'b0,4'd0,   6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b1,5'd7,32'hAA,4'd2,    1'b0,5'd0,4'd0,  5'd7,32'hAA,1'b1,4'd6,    5'd0,32'h0,1'b0,4'd0,   6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b1,5'd7,32'hBB,4'd6,    1'b0,5'd0,4'd0,  5'd7,32'hBB,1'b0,4'd0,    5'd0,32'h0,1'b0,4'd0,   6'd0));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd9,4'd1,  5'd9,32'h0,1'b1,4'd1,     5'd0,32'h0,1'b0,4'd0,   6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b1,5'd9,32'h55,4'd1,    1'b1,5'd9,4'd3,  5'd9,32'h55,1'b1,4'd3,    5'd0,32'h0,1'b0,4'd0,   6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd1,4'd7,  5'd1,32'h0,1'b1,4'd7,     5'd9,32'h55,1'b1,4'd3,  6'd2));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd2,4'd8,  5'd2,32'h0,1'b1,4'd8,     5'd1,32'h0,1'b1,4'd7,   6'd3));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd3,4'd9,  5'd3,32'h0,1'b1,4'd9,     5'd2,32'h0,1'b1,4'd8,   6'd4));
    tbl.push_back(mk(1'b1,1'b1, 1'b1,5'd1,32'h7,4'd7,     1'b1,5'd4,4'd10, 5'd1,32'h7,1'b0,4'd0,     5'd4,32'h0,1'b0,4'd0,   6'd0));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd1,4'd11, 5'd1,32'h7,1'b1,4'd11,    5'd9,32'h55,1'b0,4'd0,  6'd1));
    tbl.push_back(mk(1'b0,1'b1, 1'b1,5'd1,32'h9,4'd11,    1'b1,5'd4,4'd12, 5'd1,32'h7,1'b1,4'd11,    5'd4,32'h0,1'b0,4'd0,   6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd0,4'd5,  5'd0,32'h0,1'b0,4'd0,     5'd1,32'h7,1'b1,4'd11,  6'd1));
    tbl.push_back(mk(1'b1,1'b0, 1'b0,5'd0,32'h0,4'd0,     1'b1,5'd6,4'd5,  5'd6,32'h0,1'b1,4'd5,     5'd0,32'h0,1'b0,4'd0,   6'd2));

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      @(posedge clk_in); #1;
      drive(v.rdy, v.clr, v.ce, v.crd, v.cval, v.cid, v.re, v.rrd, v.rid);
      @(posedge clk_in); #1;
      idle(); rs1_idx = v.r1; rs2_idx = v.r2;
      #1;
      chk_port($sformatf("vec%0d.rs1", i), rs1_val, rs1_busy, rs1_tag, v.e1v, v.e1b, v.e1t);
      chk_port($sformatf("vec%0d.rs2", i), rs2_val, rs2_busy, rs2_tag, v.e2v, v.e2b, v.e2t);
      chk($sformatf("vec%0d.cnt", i), 32'(busy_cnt), 32'(v.ecnt));
    end

    // ---- same-cycle commit visibility on a busy operand (x6 tag 5) ----
    drive(1'b1, 1'b0, 1'b1, 5'd6, 32'h99, 4'd5, 1'b0, 5'd0, 4'd0);
    rs1_idx = 5'd6; rs2_idx = 5'd1;
    #1;
`ifdef REG_BYPASS_EN
    chk_port("byp_same.rs1", rs1_val, rs1_busy, rs1_tag, 32'h99, 1'b0, '0);
`else
    chk_port("byp_same.rs1", rs1_val, rs1_busy, rs1_tag, 32'h0, 1'b1, 4'd5);
`endif
    chk_port("byp_same.rs2", rs2_val, rs2_busy, rs2_tag, 32'h7, 1'b1, 4'd11);
    @(posedge clk_in); #1 idle();
    #1 chk_port("byp_next.rs1", rs1_val, rs1_busy, rs1_tag, 32'h99, 1'b0, '0);
    chk("byp_next.cnt", 32'(busy_cnt), 32'd1);

    // ---- asynchronous reset mid-operation overrides concurrent activity ----
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 4'd0, 1'b1, 5'd10, 4'd3);
    @(posedge clk_in); #1;
    rs1_idx = 5'd1; rs2_idx = 5'd10;
    drive(1'b1, 1'b1, 1'b1, 5'd1, 32'h5, 4'd11, 1'b1, 5'd12, 4'd4);
    #1 rst_in = 1'b1;
    #1;
    chk_port("rst_mid.x1", rs1_val, rs1_busy, rs1_tag, 32'h0, 1'b0, '0);
    chk_port("rst_mid.x10", rs2_val, rs2_busy, rs2_tag, 32'h0, 1'b0, '0);
    chk("rst_mid.cnt", 32'(busy_cnt), 32'd0);
    @(posedge clk_in); #1;
    rs2_idx = 5'd12;
    #1 chk_port("rst_hold.x12", rs2_val, rs2_busy, rs2_tag, 32'h0, 1'b0, '0);
    chk("rst_hold.x1val", rs1_val, 32'h0);
    idle(); rst_in = 1'b0;

    // ---- randomized traffic against the reference model ----
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bit [4:0] crd;
      @(posedge clk_in); #1;
      crd = 5'($urandom_range(0, 7));
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, 1'($urandom),
            crd, $urandom, ($urandom_range(0, 1) != 0) ? m_tag[crd] : RW'($urandom),
            1'($urandom), 5'($urandom_range(0, 7)), RW'($urandom));
      rs1_idx = 5'($urandom_range(0, 7));
      rs2_idx = 5'($urandom_range(0, 7));
      #1;
      exp_read(rs1_idx, ev, eb, et);
      chk_port($sformatf("rnd%0d.rs1", c), rs1_val, rs1_busy, rs1_tag, ev, eb, et);
      exp_read(rs2_idx, ev, eb, et);
      chk_port($sformatf("rnd%0d.rs2", c), rs2_val, rs2_busy, rs2_tag, ev, eb, et);
      chk($sformatf("rnd%0d.cnt", c), 32'(busy_cnt), 32'(model_cnt()));
      model_step(rdy_in, clear, commit_en, commit_rd, commit_val, commit_rob_id,
                 rename_en, rename_rd, rename_rob_id);
    end
    @(posedge clk_in); #1 idle();
    #1 chk("rnd_final.cnt", 32'(busy_cnt), 32'(model_cnt()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

Architectural register file with rename tags for the out-of-order core. It sits directly downstream of the reorder buffer. It takes the ROB's in-order commit writes and its tail allocations (new destination register to ROB entry), and answers the decoder's two source-operand lookups with either a committed value or the ROB id that will produce it. Flush clears all rename state; committed values survive.

## Interface
- `ROB_WIDTH`, default `` `ROB_WIDTH_BIT ``: width of a ROB entry id.
- `REG_NUM_BIT`, default 5: register index width; 32 registers.
- `clk_in`  in  1  system clock.
- `rst_in`  in  1  reset; asynchronous, active-high.
- `rdy_in`  in  1  when low, all state holds and every write/rename/clear is ignored.
- `clear`  in  1  misprediction flush; sampled only when `rdy_in` is high.
- `commit_en`  in  1  the ROB head is committing a register write this cycle.
- `commit_rd`  in  5  destination register of the committing instruction.
- `commit_val`  in  32  committed result.
- `commit_rob_id`  in  ROB_WIDTH  ROB id of the committing entry.
- `rename_en`  in  1  the decoder issued an instruction with a destination register.
- `rename_rd`  in  5  that destination register.
- `rename_rob_id`  in  ROB_WIDTH  ROB tail id allocated to it.
- `rs1_idx`, `rs2_idx`  in  5  source register indices (combinational lookup).
- `rs1_val`, `rs2_val`  out  32  register value, or the forwarded commit value.
- `rs1_busy`, `rs2_busy`  out  1  high when the operand is still pending in the ROB.
- `rs1_tag`, `rs2_tag`  out  ROB_WIDTH  producing ROB id; 0 when not busy.
- `busy_cnt`  out  6  number of registers currently busy.

## Operation
- State per register: `val[32]`, `busy`, `tag[ROB_WIDTH]`.
- x0 is never written, never renamed, and always reads 0 / not busy / tag 0.
- Commit, when `commit_en` is high and `commit_rd` is not 0:
  - `val[commit_rd] <= commit_val`.
  - `busy` clears only if `tag[commit_rd] == commit_rob_id`. Otherwise a younger rename owns the register and busy/tag are untouched.
- Rename, when `rename_en` is high and `rename_rd` is not 0: `busy[rename_rd] <= 1` and `tag[rename_rd] <= rename_rob_id`.
- Commit and rename to the same register in the same cycle:
  - The value is written.
  - The rename wins for busy and tag; the register stays busy with the new tag.
- Clear cycle (`clear` and `rdy_in` both high):
  - All busy bits drop to 0 and all tags to 0.
  - A commit in the same cycle still writes its value, because commit is architectural.
  - A rename in the same cycle is discarded.
- Read ports are purely combinational from current state.
  - A same-cycle rename is not visible to the reads. This is required so `add x5,x5,x1` sees the old mapping of x5.
- `busy_cnt` is a registered counter updated in the same cycle as the busy bits; the net change is -1, 0 or +1 per cycle.
  - Clear sets it to 0.
  - It never exceeds 31.

## Timing
- Reset, asynchronous: all `val`, `busy` and `tag` become 0, and `busy_cnt` becomes 0. Every read output is therefore 0 during and after reset.
- Reset asserted mid-operation overrides any concurrent commit, rename or clear.
- Read latency: 0 cycles (combinational).
- Rename and commit effects are visible on reads from the next rising edge.
- No handshake. Every enable is a single-cycle strobe, and the upstream blocks guarantee at most one commit and one rename per cycle.

## Configuration
- `REG_BYPASS_EN`, when defined: if a read port's register is busy, `commit_en` is high, and the port's tag equals `commit_rob_id`, the port outputs `commit_val`, busy 0 and tag 0 in the same cycle.
- Without the macro, that read reports busy with the old tag for one more cycle. Consumers then take the value from the ROB/CDB broadcast.

## Structure
- `const.v` (shared) holds `ROB_WIDTH_BIT`, `REG_NUM` = 32 and `REG_ZERO` = 0. No local redefinitions are allowed.
- One combinational sub-module, `reg_read_port`, instantiated twice. It does index lookup, the x0 override and the optional bypass.
- All storage and `busy_cnt` live in `reg_file`.

## Test plan
- Reset, then read x3 -> val 0, busy 0, tag 0; `busy_cnt` 0.
- Rename x5 to ROB 4, next cycle read x5 -> busy 1, tag 4. Commit x5, ROB 4, val 0x1234 -> next cycle busy 0, val 0x1234, `busy_cnt` 0.
- Rename x7 to ROB 2, then rename x7 to ROB 6, then commit x7 ROB 2 val 0xAA -> val 0xAA, busy 1, tag 6. Commit ROB 6 val 0xBB -> busy 0, val 0xBB.
- Same-cycle commit x9 ROB 1 val 0x55 and rename x9 to ROB 3 while x9 has tag 1 -> val 0x55, busy 1, tag 3, `busy_cnt` unchanged.
- Rename x1, x2, x3, then `clear` with a same-cycle rename of x4 and commit x1 val 7 -> all busy 0, x1 = 7, x4 not busy, `busy_cnt` 0. Repeat with `rdy_in` low -> no change.
- With `REG_BYPASS_EN` defined: x6 busy with tag 5, commit ROB 5 val 0x99, rs1_idx=6 -> same cycle rs1_val 0x99, busy 0. Without the macro -> busy 1, tag 5. Rename x0 -> reads remain 0 / not busy.
